// File: rtl/mc_lb_pkg.sv
// -----------------------------------------------------------------------------
// mc_lb_pkg
//   Shared types and defaults for the MC loopback responder.
//   - mc_lb_state_t : replay FSM states (IDLE, GAP, SEND)
//   - mc_lb_entry_t : one buffered beat {last, data} at the default data width
//   - MC_LB_DATA_W / MC_LB_GAP_CYCLES : default width and inter-burst gap
// -----------------------------------------------------------------------------
package mc_lb_pkg;

  localparam int MC_LB_DATA_W     = 64;
  localparam int MC_LB_GAP_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SEND = 2'd2
  } mc_lb_state_t;

  typedef struct packed {
    logic                    last;
    logic [MC_LB_DATA_W-1:0] data;
  } mc_lb_entry_t;

endpackage

// File: rtl/mc_lb_fifo.sv
// -----------------------------------------------------------------------------
// mc_lb_fifo
//   Synchronous show-ahead FIFO. The head entry is visible on o_rdata
//   whenever o_empty is low; i_pop advances past it at the next clock.
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   without a separate occupancy counter.
//
// Ports
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (pointers only)
//   i_push   in   write i_wdata (ignored while full)
//   i_wdata  in   WIDTH-bit entry to write
//   i_pop    in   drop the head entry (ignored while empty)
//   o_rdata  out  head entry
//   o_full   out  DEPTH entries stored
//   o_empty  out  no entries stored
// -----------------------------------------------------------------------------
module mc_lb_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty   = (r_wptr == r_rptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage carries no reset; stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/mc_loopback_responder.sv
// -----------------------------------------------------------------------------
// mc_loopback_responder
//   Memory-controller-side responder: terminates the MC write-data (W)
//   channel into a FIFO and replays each captured burst on the MC read-data
//   (R) channel, preceded by GAP_CYCLES idle cycles. Default build is
//   store-and-forward: a burst is replayed only once its wlast beat is stored.
//
//   Build option MC_LB_CUT_THROUGH_EN (define to enable): replay starts as
//   soon as any beat is buffered, rvalid drops while the FIFO runs dry
//   mid-burst, and the overflow detector is removed (ovf_err tied to 0).
//
// Parameters
//   DATA_W      W/R data width
//   DEPTH       FIFO depth in beats (power of two, >= 2)
//   GAP_CYCLES  idle cycles before each R burst (0 = back-to-back)
//
// Ports
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   wvalid     in   W beat valid
//   wdata      in   W beat data
//   wlast      in   last beat of W burst
//   wready     out  W beat accept (low in reset and while FIFO full)
//   rvalid     out  R beat valid
//   rdata      out  R beat data (0 when rvalid=0)
//   rlast      out  last beat of R burst (0 when rvalid=0)
//   rready     in   R beat accept
//   burst_cnt  out  complete bursts currently buffered
//   ovf_err    out  sticky: FIFO filled without a complete burst stored
// -----------------------------------------------------------------------------
module mc_loopback_responder
  import mc_lb_pkg::*;
#(
  parameter int DATA_W     = MC_LB_DATA_W,
  parameter int DEPTH      = 64,
  parameter int GAP_CYCLES = MC_LB_GAP_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wvalid,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       wlast,
  output logic                       wready,
  output logic                       rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rlast,
  input  logic                       rready,
  output logic [$clog2(DEPTH+1)-1:0] burst_cnt,
  output logic                       ovf_err
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE       = 1;
  localparam logic [GAP_W-1:0] GAP_ONE       = 1;
  // Between bursts the GAP state provides all GAP_CYCLES idle cycles.
  localparam logic [GAP_W-1:0] GAP_LOAD_SEND = GAP_W'(GAP_CYCLES);
  // Coming from IDLE, the cycle spent in IDLE noticing the burst already
  // counts as the first idle cycle, so GAP covers one fewer.
  localparam logic [GAP_W-1:0] GAP_LOAD_IDLE = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  mc_lb_state_t r_state;
  mc_lb_state_t w_state_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_nxt;
  logic r_forced;     // currently replaying an overflowed (uncounted) burst
  logic r_fwl_seen;   // that burst's wlast has already been stored

  logic [DATA_W:0] w_fifo_wdata;
  logic [DATA_W:0] w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_head_last;

  logic w_push;
  logic w_pop;
  logic w_pop_last;
  logic w_inc;
  logic w_dec;
  logic w_start;
  logic w_force;

  // ---------------------------------------------------------------------------
  // Beat buffer
  // ---------------------------------------------------------------------------
  assign w_fifo_wdata = {wlast, wdata};

  mc_lb_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_last = w_head[DATA_W];

  // ---------------------------------------------------------------------------
  // Channel handshakes
  // ---------------------------------------------------------------------------
  // wready reflects the pre-pop full state, so a pop in a full cycle frees
  // space only from the next cycle on.
  assign wready     = rst_n && !w_full;
  assign rvalid     = (r_state == SEND) && !w_empty;
  assign rdata      = rvalid ? w_head[DATA_W-1:0] : '0;
  assign rlast      = rvalid && w_head_last;
  assign w_push     = wvalid && wready;
  assign w_pop      = rvalid && rready;
  assign w_pop_last = w_pop && w_head_last;
  assign burst_cnt  = r_burst_cnt;

`ifdef MC_LB_CUT_THROUGH_EN
  assign w_start = !w_empty;
  assign w_force = 1'b0;
  assign ovf_err = 1'b0;
`else
  assign w_start = (r_burst_cnt != '0);
  // A full FIFO with no complete burst can never drain by itself; stream it
  // out cut-through instead of deadlocking.
  assign w_force = w_full && (r_burst_cnt == '0) && !r_forced;

  logic r_ovf_err;
  assign ovf_err = r_ovf_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_err <= 1'b0;
    end else if (w_force) begin
      r_ovf_err <= 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Complete-burst counter
  // ---------------------------------------------------------------------------
  // The overflowed burst was never counted, so neither its wlast push nor its
  // rlast pop touches the counter. Later bursts queued behind it count
  // normally.
  assign w_inc = w_push && wlast && !(r_forced && !r_fwl_seen);
  assign w_dec = w_pop_last && !r_forced;

  always_comb begin
    w_burst_nxt = r_burst_cnt;
    if (w_inc && !w_dec) begin
      w_burst_nxt = r_burst_cnt + CNT_ONE;
    end else if (!w_inc && w_dec) begin
      w_burst_nxt = r_burst_cnt - CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Replay FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_force) begin
          w_state_nxt = SEND;
        end else if (w_start) begin
          if (GAP_CYCLES > 1) begin
            w_state_nxt = GAP;
            w_gap_nxt   = GAP_LOAD_IDLE;
          end else begin
            w_state_nxt = SEND;
          end
        end
      end
      GAP: begin
        if (w_force || (r_gap_cnt <= GAP_ONE)) begin
          w_state_nxt = SEND;
        end else begin
          w_gap_nxt = r_gap_cnt - GAP_ONE;
        end
      end
      SEND: begin
        // In forced mode the FIFO may run dry; rvalid is low and the FSM
        // simply waits here for the next beat.
        if (w_pop_last) begin
          if (w_burst_nxt != '0) begin
            if (GAP_CYCLES > 0) begin
              w_state_nxt = GAP;
              w_gap_nxt   = GAP_LOAD_SEND;
            end else begin
              w_state_nxt = SEND;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gap_cnt   <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  // Forced-burst tracking: set on overflow, closed by the stored rlast.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_forced   <= 1'b0;
      r_fwl_seen <= 1'b0;
    end else if (w_force) begin
      r_forced   <= 1'b1;
      r_fwl_seen <= 1'b0;
    end else if (r_forced) begin
      if (w_push && wlast) begin
        r_fwl_seen <= 1'b1;
      end
      if (w_pop_last) begin
        r_forced   <= 1'b0;
        r_fwl_seen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mc_loopback_responder.sv
// -----------------------------------------------------------------------------
// tb_mc_loopback_responder
//   Scoreboard bench for mc_loopback_responder (DEPTH=8, GAP_CYCLES=2).
//   Accepted W beats are queued; every R handshake pops and compares.
//   Also honours MC_LB_CUT_THROUGH_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_mc_loopback_responder;
  import mc_lb_pkg::*;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int GAP    = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef logic [DATA_W:0] val_t;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              wvalid = 1'b0;
  logic [DATA_W-1:0] wdata  = '0;
  logic              wlast  = 1'b0;
  logic              rready = 1'b0;
  logic              wready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic [CNT_W-1:0]  burst_cnt;
  logic              ovf_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mc_lb_entry_t sb[$];
  int           acc_cyc[$];
  int           pop_cyc[$];
  val_t         prev_r;
  bit           prev_stall = 1'b0;

  mc_loopback_responder #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wvalid    (wvalid),
    .wdata     (wdata),
    .wlast     (wlast),
    .wready    (wready),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rlast     (rlast),
    .rready    (rready),
    .burst_cnt (burst_cnt),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input val_t act, input val_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // R-side monitor: scoreboard compare, AXI hold rule, zero-when-idle.
  always @(negedge clk) begin
    mc_lb_entry_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("r_hold_valid", val_t'(rvalid), val_t'(1));
        chk("r_hold_data", {rlast, rdata}, prev_r);
      end
      if (!rvalid) chk("r_idle_zero", {rlast, rdata}, val_t'(0));
      if (rvalid && rready) begin
        pop_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("r_unexpected", val_t'(1), val_t'(0));
        end else begin
          e = sb.pop_front();
          chk("r_data", val_t'(rdata), val_t'(e.data));
          chk("r_last", val_t'(rlast), val_t'(e.last));
        end
      end
      prev_stall = rvalid && !rready;
      prev_r     = {rlast, rdata};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wbeat(input logic [DATA_W-1:0] d, input logic l);
    bit done;
    mc_lb_entry_t e;
    done   = 1'b0;
    wvalid = 1'b1;
    wdata  = d;
    wlast  = l;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (wready) begin
        e.last = l;
        e.data = d;
        sb.push_back(e);
        acc_cyc.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("w_accept", val_t'(done), val_t'(1));
  endtask

  task automatic wait_rvalid(input string tag);
    int i;
    i = 0;
    while (i < 100 && !rvalid) begin
      tick(1);
      i++;
    end
    chk({tag, "_rvalid_seen"}, val_t'(rvalid), val_t'(1));
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (i < 300 && (sb.size() != 0 || rvalid)) begin
      tick(1);
      i++;
    end
    chk({tag, "_drained"}, val_t'(sb.size()), val_t'(0));
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    pop_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int gap;

    // Reset state
    rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_wready", val_t'(wready), val_t'(0));
    chk("rst_rvalid", val_t'(rvalid), val_t'(0));
    chk("rst_rdata", val_t'(rdata), val_t'(0));
    chk("rst_rlast", val_t'(rlast), val_t'(0));
    chk("rst_burst_cnt", val_t'(burst_cnt), val_t'(0));
    chk("rst_ovf_err", val_t'(ovf_err), val_t'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wready_after", val_t'(wready), val_t'(1));
    @(posedge clk);
    #1;

    // T1: single 4-beat burst, rready high
    rready = 1'b1;
    clear_logs();
    wbeat(64'h11, 1'b0);
    wbeat(64'h22, 1'b0);
    wbeat(64'h33, 1'b0);
    chk("t1_cnt_before", val_t'(burst_cnt), val_t'(0));
    wbeat(64'h44, 1'b1);
    chk("t1_cnt_one", val_t'(burst_cnt), val_t'(1));
    drain("t1");
    chk("t1_beats", val_t'(pop_cyc.size()), val_t'(4));
`ifdef MC_LB_CUT_THROUGH_EN
    lat = (pop_cyc.size() > 0 && acc_cyc.size() > 0) ? pop_cyc[0] - acc_cyc[0] : -1;
`else
    lat = (pop_cyc.size() > 0 && acc_cyc.size() > 3) ? pop_cyc[0] - acc_cyc[3] : -1;
`endif
    chk("t1_latency", val_t'(lat), val_t'(GAP + 1));
    chk("t1_cnt_zero", val_t'(burst_cnt), val_t'(0));

    // T2: two 2-beat bursts under R backpressure
    rready = 1'b0;
    clear_logs();
    wbeat(64'hA1, 1'b0);
    wbeat(64'hA2, 1'b1);
    wbeat(64'hB1, 1'b0);
    wbeat(64'hB2, 1'b1);
    chk("t2_cnt_two", val_t'(burst_cnt), val_t'(2));
    tick(10);
    chk("t2_stall_valid", val_t'(rvalid), val_t'(1));
    chk("t2_stall_data", val_t'(rdata), val_t'(64'hA1));
    rready = 1'b1;
    drain("t2");
    chk("t2_beats", val_t'(pop_cyc.size()), val_t'(4));
    gap = (pop_cyc.size() > 2) ? pop_cyc[2] - pop_cyc[1] - 1 : -1;
    chk("t2_gap", val_t'(gap), val_t'(GAP));
    chk("t2_cnt_zero", val_t'(burst_cnt), val_t'(0));

`ifndef MC_LB_CUT_THROUGH_EN
    // T3: burst longer than the FIFO forces cut-through replay
    rready = 1'b0;
    clear_logs();
    chk("t3_ovf_before", val_t'(ovf_err), val_t'(0));
    for (int i = 0; i < DEPTH; i++) wbeat(64'h100 + 64'(i), 1'b0);
    @(negedge clk);
    chk("t3_full_wready", val_t'(wready), val_t'(0));
    chk("t3_cnt_full", val_t'(burst_cnt), val_t'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_ovf_set", val_t'(ovf_err), val_t'(1));
    chk("t3_forced_rvalid", val_t'(rvalid), val_t'(1));
    chk("t3_forced_head", val_t'(rdata), val_t'(64'h100));
    @(posedge clk);
    #1;
    rready = 1'b1;
    wbeat(64'h1FF, 1'b1);
    chk("t3_cnt_after_wlast", val_t'(burst_cnt), val_t'(0));
    drain("t3");
    chk("t3_beats", val_t'(pop_cyc.size()), val_t'(DEPTH + 1));
    chk("t3_cnt_end", val_t'(burst_cnt), val_t'(0));
    chk("t3_ovf_sticky", val_t'(ovf_err), val_t'(1));
`endif

    // T4: wlast push and rlast pop in the same cycle
    rready = 1'b0;
    clear_logs();
    wbeat(64'hC1, 1'b0);
    wbeat(64'hC2, 1'b1);
    wbeat(64'hD1, 1'b0);
    chk("t4_cnt_one", val_t'(burst_cnt), val_t'(1));
    wait_rvalid("t4");
    rready = 1'b1;
    tick(1);
    wvalid = 1'b1;
    wdata  = 64'hD2;
    wlast  = 1'b1;
    @(negedge clk);
    chk("t4_coincide", val_t'({rvalid && rready && rlast, wvalid && wready && wlast}), val_t'(3));
    if (wready) begin
      mc_lb_entry_t e;
      e.last = 1'b1;
      e.data = 64'hD2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("t4_cnt_kept", val_t'(burst_cnt), val_t'(1));
    drain("t4");
    chk("t4_beats", val_t'(pop_cyc.size()), val_t'(4));
    chk("t4_cnt_zero", val_t'(burst_cnt), val_t'(0));

    // T5: reset in the middle of an R burst
    rready = 1'b0;
    clear_logs();
    wbeat(64'hE1, 1'b0);
    wbeat(64'hE2, 1'b0);
    wbeat(64'hE3, 1'b0);
    wbeat(64'hE4, 1'b1);
    wait_rvalid("t5");
    rready = 1'b1;
    tick(1);
    rready = 1'b0;
    rst_n  = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t5_wready_in_rst", val_t'(wready), val_t'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rvalid", val_t'(rvalid), val_t'(0));
    chk("t5_cnt", val_t'(burst_cnt), val_t'(0));
    chk("t5_wready", val_t'(wready), val_t'(1));
    chk("t5_ovf_clr", val_t'(ovf_err), val_t'(0));
    @(posedge clk);
    #1;
    clear_logs();
    rready = 1'b1;
    wbeat(64'hAA, 1'b1);
    drain("t5");
    chk("t5_beats", val_t'(pop_cyc.size()), val_t'(1));
    chk("t5_cnt_zero", val_t'(burst_cnt), val_t'(0));

`ifdef MC_LB_CUT_THROUGH_EN
    // T6: cut-through start and mid-burst underrun
    rready = 1'b1;
    clear_logs();
    wbeat(64'hF0, 1'b0);
    wbeat(64'hF1, 1'b0);
    wbeat(64'hF2, 1'b0);
    tick(3);
    wbeat(64'hF3, 1'b1);
    drain("t6");
    chk("t6_beats", val_t'(pop_cyc.size()), val_t'(4));
    lat = (pop_cyc.size() > 0) ? pop_cyc[0] - acc_cyc[0] : -1;
    chk("t6_start", val_t'(lat), val_t'(GAP + 1));
    gap = (pop_cyc.size() > 3) ? pop_cyc[3] - pop_cyc[2] : 0;
    chk("t6_drop", val_t'(gap > 1), val_t'(1));
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
